// File: rtl/motor_relu_layer_seq.sv
// Sequencing controller for one activation layer of the motor MPC network.
// Streams N_ELEM pre-activation words through a shared ReLU unit onto a registered output stream.
module motor_relu_layer_seq #(
    parameter int unsigned N_ELEM = 16,
    parameter int unsigned DATA_W = 18,
    parameter int unsigned OUT_W  = 17,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic              ap_done,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] relu_x,
    input  logic [OUT_W-1:0]  relu_y,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  clip_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_ELEM);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             accept;
    logic             consume;
    logic             in_is_last;
    logic             in_is_clip;
    logic             pass_start;

    // Handshake decode; the output register may reload in the cycle it drains.
    assign in_ready   = (state == S_RUN) & (~out_valid | out_ready);
    assign accept     = in_valid & in_ready;
    assign consume    = out_valid & out_ready;
    assign in_is_last = (in_cnt == LAST_IDX);
    assign in_is_clip = in_data[DATA_W-1] | (in_data == '0);
    assign pass_start = (state == S_IDLE) & ap_start;

    assign relu_x   = in_data;
    assign ap_idle  = (state == S_IDLE);
    assign ap_done  = (state == S_DONE);
    assign ap_ready = accept & in_is_last;

    // State register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ap_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && in_is_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (consume && out_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output register and pass counters; counters saturate at N_ELEM.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            clip_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (pass_start) begin
                in_cnt   <= '0;
                out_cnt  <= '0;
                clip_cnt <= '0;
            end

            if (accept) begin
                out_data  <= relu_y;
                out_valid <= 1'b1;
                out_last  <= in_is_last;
                if (in_cnt != FULL_CNT) begin
                    in_cnt <= in_cnt + CNT_W'(1);
                end
                if (in_is_clip) begin
                    clip_cnt <= clip_cnt + CNT_W'(1);
                end
            end else if (consume) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (consume && (out_cnt != FULL_CNT)) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/motor_relu_layer_seq.md
Name: motor_relu_layer_seq

Overview:
- Sequencing controller for one activation layer of the motor MPC network.
- Accepts one layer's N_ELEM pre-activation words from the preceding dense stage over a valid/ready stream.
- Drives each word through a single shared combinational ReLU unit (ap_fixed<18,7> in, 17-bit non-negative out) and registers the result onto an output valid/ready stream.
- Provides ap_start/ap_done/ap_idle/ap_ready block-level control and a per-layer clip counter for debug and telemetry.

Parameters:
- N_ELEM, 16, number of activations per layer invocation (>=1).
- DATA_W, 18, input word width (ap_fixed<18,7>, two's complement, 11 fractional bits).
- OUT_W, 17, output word width (DATA_W-1; sign bit dropped).
- CNT_W, 5, counter width; must satisfy 2**CNT_W > N_ELEM.

Ports:
- ap_clk  in  1  clock; all state updates on its rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- ap_start  in  1  start one layer pass; sampled only in IDLE.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  one-cycle pulse when the N_ELEM-th input is accepted.
- ap_done  out  1  one-cycle pulse in DONE.
- in_data  in  DATA_W  pre-activation word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller accepts in_data this cycle.
- relu_x  out  DATA_W  operand to the shared ReLU unit; equals in_data (combinational).
- relu_y  in  OUT_W  ReLU result for relu_x; combinational, same cycle.
- out_data  out  OUT_W  registered activation.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  qualifies the N_ELEM-th output beat.
- clip_cnt  out  CNT_W  number of inputs in the current or most recent pass with in_data <= 0.

Behaviour:
- Reset (async, ap_rst=1) sets:
  - state=IDLE, ap_idle=1;
  - in_cnt=0, out_cnt=0, clip_cnt=0;
  - out_valid=0, out_data=0, out_last=0, ap_ready=0, ap_done=0.
- Reset asserted mid-pass aborts the pass. No partial output beat survives, and no ap_done is produced.
- States:
  - IDLE: ap_start=1 -> RUN; clear in_cnt, out_cnt and clip_cnt.
  - RUN: accept inputs. When the N_ELEM-th input is accepted -> DRAIN.
  - DRAIN: in_ready=0. When the beat with out_last is consumed (out_valid & out_ready & out_last) -> DONE.
  - DONE: ap_done=1 for exactly one cycle -> IDLE.
- ap_start outside IDLE is ignored. There is no queued start.
- in_ready = (state==RUN) & (!out_valid | out_ready). It is 0 in IDLE, DRAIN and DONE.
- Input accept = in_valid & in_ready. On accept:
  - out_data <= relu_y, out_valid <= 1;
  - out_last <= (in_cnt==N_ELEM-1);
  - in_cnt++;
  - clip_cnt++ if the signed value in_data <= 0.
- Output consume = out_valid & out_ready. On consume without a same-cycle accept, out_valid <= 0. On consume with a same-cycle accept, the register reloads with out_valid held at 1 (full throughput, one word per cycle).
- Latency: input accepted at edge t appears on out_data/out_valid after edge t (visible in cycle t+1).
- Stall rules: while out_valid=1 and out_ready=0, out_data, out_last and out_valid hold, and in_ready=0. No word is dropped or duplicated.
- ap_ready pulses in the cycle the N_ELEM-th input is accepted (combinational from the accept condition).
- ReLU contract, checked by the bench: relu_y = (signed in_data > 0) ? in_data[OUT_W-1:0] : 0. The controller does not re-saturate.
- clip_cnt holds its final value through IDLE until the next ap_start.
- in_cnt and out_cnt never exceed N_ELEM. There is no wrap within a pass.
- N_ELEM=1 edge case: the first accept sets out_last=1, pulses ap_ready, and moves to DRAIN in the same edge.

Test Plan:
- Reset, then ap_start with N_ELEM=4, inputs 0x00800 (+1.0), 0x3F800 (-1.0), 0x00000, 0x1FFFF, out_ready=1 throughout:
  - outputs 0x00800, 0x00000, 0x00000, 0x1FFFF on consecutive cycles;
  - out_last on the 4th beat; ap_ready coincides with the 4th accept;
  - ap_done one cycle after the last consume; clip_cnt=2.
- Backpressure: out_ready=0 for 5 cycles after the first output beat:
  - out_data holds 0x00800 and in_ready=0 for those 5 cycles;
  - resume gives the in-order, lossless sequence and the same final clip_cnt.
- Bubbly input: in_valid toggles 1/0 -> out_valid follows one cycle later; out_cnt reaches exactly N_ELEM; exactly one ap_done.
- ap_start pulsed during RUN and during DRAIN -> ignored; exactly one pass and one ap_done; the next ap_start in IDLE begins a fresh pass with clip_cnt cleared.
- Assert ap_rst after 2 of 4 accepts -> all outputs take their reset values immediately; no ap_done; the subsequent full pass is correct.
- Throughput: in_valid=1 and out_ready=1 continuously for N_ELEM=16 -> 16 accepts in 16 consecutive cycles with zero bubbles.
